// File: rtl/otter_branch_resolve.sv
// rtl/otter_branch_resolve.sv - execute-stage branch/jump resolution with redirect, flush window and perf counters
module otter_branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_is_br,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic             br_eq,
  input  logic             br_lt,
  input  logic             br_ltu,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_rs1,
  input  logic [31:0]      ex_imm,
  output logic             redirect_vld,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             link_vld,
  output logic [31:0]      link_data,
  output logic             misalign,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_e;

  // FLUSH state lasts FLUSH_CYCLES-1 cycles; the counter is loaded with one less and runs to zero.
  localparam int FC_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = (FLUSH_CYCLES > 2) ? FC_W'(FLUSH_CYCLES - 2) : '0;

  state_e            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic              link_vld_q, link_vld_d;
  logic [31:0]       link_data_q, link_data_d;
  logic              misalign_q, misalign_d;
  logic              illegal_br_q, illegal_br_d;
  logic [CNT_W-1:0]  br_count_q, br_count_d;
  logic [CNT_W-1:0]  taken_count_q, taken_count_d;

  logic        is_jalr, is_jal, is_br;
  logic        accept, cond, illegal_f3, taken, aligned, go_redirect;
  logic [31:0] jalr_sum, target;

  // Decode with jalr > jal > br priority, evaluate the branch condition and the target.
  always_comb begin
    is_jalr    = ex_is_jalr;
    is_jal     = ex_is_jal & ~ex_is_jalr;
    is_br      = ex_is_br & ~ex_is_jal & ~ex_is_jalr;
    accept     = ex_valid & (state_q == S_IDLE) & (ex_is_br | ex_is_jal | ex_is_jalr);
    illegal_f3 = 1'b0;
    cond       = 1'b0;
    case (ex_funct3)
      3'b000:  cond = br_eq;
      3'b001:  cond = ~br_eq;
      3'b100:  cond = br_lt;
      3'b101:  cond = ~br_lt;
      3'b110:  cond = br_ltu;
      3'b111:  cond = ~br_ltu;
      default: illegal_f3 = 1'b1;
    endcase
    jalr_sum    = ex_rs1 + ex_imm;
    target      = is_jalr ? {jalr_sum[31:1], 1'b0} : (ex_pc + ex_imm);
    taken       = is_jal | is_jalr | (is_br & cond);
    aligned     = (target[1:0] == 2'b00);
    go_redirect = accept & taken & aligned;
  end

  // Next state: a redirect cycle followed by the remaining flush window.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (go_redirect) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (FLUSH_CYCLES > 1) begin
          state_d = S_FLUSH;
          fcnt_d  = FC_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (fcnt_q == '0) state_d = S_IDLE;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result registers: pulses clear each cycle, data fields update only on accept.
  always_comb begin
    redirect_pc_d = redirect_pc_q;
    link_data_d   = link_data_q;
    link_vld_d    = 1'b0;
    misalign_d    = 1'b0;
    illegal_br_d  = 1'b0;
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    if (accept) begin
      redirect_pc_d = target;
      link_data_d   = ex_pc + 32'd4;
      link_vld_d    = is_jal | is_jalr;
      misalign_d    = taken & ~aligned;
      illegal_br_d  = is_br & illegal_f3;
      if (is_br && (br_count_q != '1))
        br_count_d = br_count_q + CNT_W'(1);
      if (is_br && cond && (taken_count_q != '1))
        taken_count_d = taken_count_q + CNT_W'(1);
    end
  end

  // State and result flops; reset aborts any flush window immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      fcnt_q        <= '0;
      redirect_pc_q <= '0;
      link_vld_q    <= 1'b0;
      link_data_q   <= '0;
      misalign_q    <= 1'b0;
      illegal_br_q  <= 1'b0;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      redirect_pc_q <= redirect_pc_d;
      link_vld_q    <= link_vld_d;
      link_data_q   <= link_data_d;
      misalign_q    <= misalign_d;
      illegal_br_q  <= illegal_br_d;
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign ex_ready     = (state_q == S_IDLE);
  assign flush        = (state_q != S_IDLE);
  assign redirect_vld = (state_q == S_REDIRECT);
  assign redirect_pc  = redirect_pc_q;
  assign link_vld     = link_vld_q;
  assign link_data    = link_data_q;
  assign misalign     = misalign_q;
  assign illegal_br   = illegal_br_q;
  assign br_count     = br_count_q;
  assign taken_count  = taken_count_q;

endmodule

// File: tb/tb_otter_branch_resolve.sv
// tb/tb_otter_branch_resolve.sv - vectors, directed sequences and randomized model checks for otter_branch_resolve
module tb_otter_branch_resolve;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ex_valid, ex_is_br, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic        br_eq, br_lt, br_ltu;
  logic [31:0] ex_pc, ex_rs1, ex_imm;

  logic        ex_ready, redirect_vld, flush, link_vld, misalign, illegal_br;
  logic [31:0] redirect_pc, link_data, br_count, taken_count;

  logic        s_ready, s_rv, s_flush, s_lv, s_mis, s_ill;
  logic [31:0] s_rpc, s_ld;
  logic [3:0]  s_brc, s_tkc;

  otter_branch_resolve #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_br(ex_is_br), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_imm(ex_imm),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc), .flush(flush),
    .link_vld(link_vld), .link_data(link_data), .misalign(misalign), .illegal_br(illegal_br),
    .br_count(br_count), .taken_count(taken_count));

  otter_branch_resolve #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(s_ready),
    .ex_is_br(ex_is_br), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_imm(ex_imm),
    .redirect_vld(s_rv), .redirect_pc(s_rpc), .flush(s_flush),
    .link_vld(s_lv), .link_data(s_ld), .misalign(s_mis), .illegal_br(s_ill),
    .br_count(s_brc), .taken_count(s_tkc));

  int checks = 0;
  int failures = 0;

  // Reference model: blocked-cycle budget, unbounded event counts, last results.
  int          m_blk;
  longint      m_brc, m_tkc;
  bit          m_rv, m_lv, m_mis, m_ill;
  bit [31:0]   m_rpc, m_ld;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input longint c, input int w);
    longint mx = (64'd1 << w) - 1;
    return (c > mx) ? mx[31:0] : c[31:0];
  endfunction

  task automatic model_clear();
    m_blk = 0; m_brc = 0; m_tkc = 0;
    m_rv = 0; m_lv = 0; m_mis = 0; m_ill = 0; m_rpc = 0; m_ld = 0;
  endtask

  task automatic model_edge();
    bit acc, cnd, tk, al, bad;
    int kind;
    logic [31:0] sum, tgt;
    acc = ex_valid && (m_blk == 0) && (ex_is_br || ex_is_jal || ex_is_jalr);
    kind = ex_is_jalr ? 2 : (ex_is_jal ? 1 : 0);
    bad = (ex_funct3 == 3'd2) || (ex_funct3 == 3'd3);
    case (ex_funct3)
      3'd0: cnd = br_eq;   3'd1: cnd = !br_eq;
      3'd4: cnd = br_lt;   3'd5: cnd = !br_lt;
      3'd6: cnd = br_ltu;  3'd7: cnd = !br_ltu;
      default: cnd = 0;
    endcase
    sum = ex_rs1 + ex_imm;
    tgt = (kind == 2) ? (sum - (sum % 2)) : (ex_pc + ex_imm);
    tk  = (kind != 0) || cnd;
    al  = (tgt % 4) == 0;
    m_rv = 0; m_lv = 0; m_mis = 0; m_ill = 0;
    if (m_blk > 0) m_blk--;
    else if (acc && tk && al) m_blk = FC;
    if (acc) begin
      m_rv  = tk && al;
      m_lv  = (kind != 0);
      m_mis = tk && !al;
      m_ill = (kind == 0) && bad;
      m_rpc = tgt;
      m_ld  = ex_pc + 4;
      if (kind == 0) begin
        m_brc++;
        if (cnd) m_tkc++;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("ex_ready", ex_ready, m_blk == 0);
    chk("flush", flush, m_blk > 0);
    chk("redirect_vld", redirect_vld, m_rv);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("link_vld", link_vld, m_lv);
    chk("link_data", link_data, m_ld);
    chk("misalign", misalign, m_mis);
    chk("illegal_br", illegal_br, m_ill);
    chk("br_count", br_count, sat(m_brc, 32));
    chk("taken_count", taken_count, sat(m_tkc, 32));
    chk("br_count4", s_brc, sat(m_brc, 4));
    chk("taken_count4", s_tkc, sat(m_tkc, 4));
    chk("ex_ready4", s_ready, m_blk == 0);
  endtask

  task automatic drive(input bit v, input bit b, input bit j, input bit jr, input bit [2:0] f3,
                       input bit eq, input bit lt, input bit ltu,
                       input bit [31:0] pc, input bit [31:0] rs1, input bit [31:0] imm);
    ex_valid = v; ex_is_br = b; ex_is_jal = j; ex_is_jalr = jr; ex_funct3 = f3;
    br_eq = eq; br_lt = lt; br_ltu = ltu; ex_pc = pc; ex_rs1 = rs1; ex_imm = imm;
  endtask

  task automatic idle(input int n);
    ex_valid = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    ex_valid = 0;
    rst_n = 0;
    model_clear();
    #2;
    chk("rst_ready", ex_ready, 1);
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_vld, 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_brc", br_count, 0);
    chk("rst_tkc", taken_count, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    bit b, j, jr; bit [2:0] f3; bit eq, lt, ltu;
    bit [31:0] pc, rs1, imm;
    bit e_rv; bit [31:0] e_rpc; bit e_lv, e_mis, e_ill;
  } vec_t;
  vec_t tbl[10];

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 0;
    model_clear();
    #12;
    do_reset();

    // BEQ taken: redirect next cycle, 2-cycle flush.
    drive(1, 1, 0, 0, 3'b000, 1, 0, 0, 32'h100, 0, 32'h20);
    cycle();
    chk("beq_rv", redirect_vld, 1); chk("beq_pc", redirect_pc, 32'h120);
    chk("beq_flush0", flush, 1); chk("beq_ready0", ex_ready, 0); chk("beq_tkc", taken_count, 1);
    ex_valid = 0;
    cycle();
    chk("beq_flush1", flush, 1); chk("beq_ready1", ex_ready, 0); chk("beq_rv1", redirect_vld, 0);
    cycle();
    chk("beq_flush2", flush, 0); chk("beq_ready2", ex_ready, 1);

    // BLTU not taken then BNE taken back-to-back.
    do_reset();
    drive(1, 1, 0, 0, 3'b110, 0, 0, 0, 32'h200, 0, 32'h10);
    cycle();
    chk("bltu_rv", redirect_vld, 0); chk("bltu_ready", ex_ready, 1);
    drive(1, 1, 0, 0, 3'b001, 0, 0, 0, 32'h204, 0, 32'h40);
    cycle();
    chk("bne_rv", redirect_vld, 1); chk("bne_pc", redirect_pc, 32'h244); chk("bne_brc", br_count, 2);
    idle(3);

    // JALR to odd-cleared but still misaligned target.
    do_reset();
    drive(1, 0, 0, 1, 3'b000, 0, 0, 0, 32'h40, 32'h1003, 0);
    cycle();
    chk("jalr_mis", misalign, 1); chk("jalr_rv", redirect_vld, 0); chk("jalr_flush", flush, 0);
    chk("jalr_lv", link_vld, 1); chk("jalr_ld", link_data, 32'h44); chk("jalr_pc", redirect_pc, 32'h1002);
    idle(2);

    // JAL wrap; branch presented during flush is ignored.
    do_reset();
    drive(1, 0, 1, 0, 3'b000, 0, 0, 0, 32'hFFFF_FFFC, 0, 32'h8);
    cycle();
    chk("jal_pc", redirect_pc, 32'h4); chk("jal_ld", link_data, 32'h0);
    drive(1, 1, 0, 0, 3'b000, 1, 0, 0, 32'h80, 0, 32'h8);
    cycle(); cycle();
    ex_valid = 0;
    cycle();
    chk("jal_ign_brc", br_count, 0); chk("jal_ign_tkc", taken_count, 0); chk("jal_ign_rv", redirect_vld, 0);

    // Illegal funct3.
    drive(1, 1, 0, 0, 3'b010, 1, 1, 1, 32'h300, 0, 32'h8);
    cycle();
    chk("ill_pulse", illegal_br, 1); chk("ill_rv", redirect_vld, 0); chk("ill_brc", br_count, 1);
    ex_valid = 0;
    cycle();
    chk("ill_pulse_end", illegal_br, 0);

    // 16 taken branches saturate the 4-bit counter.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 3'b000, 1, 0, 0, 32'h0, 0, 32'h4);
      cycle();
      idle(2);
    end
    chk("sat_tkc4", s_tkc, 4'hF); chk("sat_brc4", s_brc, 4'hF); chk("sat_tkc32", taken_count, 16);

    // Reset asserted inside the FLUSH state.
    drive(1, 1, 0, 0, 3'b000, 1, 0, 0, 32'h100, 0, 32'h20);
    cycle();
    ex_valid = 0;
    cycle();
    chk("mid_flush", flush, 1);
    rst_n = 0;
    model_clear();
    #1;
    chk("async_flush", flush, 0); chk("async_rv", redirect_vld, 0); chk("async_pc", redirect_pc, 0);
    chk("async_tkc", taken_count, 0);
    @(negedge clk);
    rst_n = 1;
    cycle();
    chk("post_rst_ready", ex_ready, 1);

    // Vector table: one accept from idle per entry.
    tbl[0] = '{1, 0, 0, 3'b000, 1, 0, 0, 32'h100, 0, 32'h20, 1, 32'h120, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 3'b001, 1, 0, 0, 32'h200, 0, 32'h40, 0, 32'h240, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 3'b100, 0, 1, 0, 32'h300, 0, 32'hFFFF_FFFC, 1, 32'h2FC, 0, 0, 0};
    tbl[3] = '{1, 0, 0, 3'b111, 0, 1, 0, 32'h1000, 0, 32'h10, 1, 32'h1010, 0, 0, 0};
    tbl[4] = '{0, 1, 0, 3'b000, 0, 0, 0, 32'h400, 0, 32'h6, 0, 32'h406, 1, 1, 0};
    tbl[5] = '{0, 0, 1, 3'b000, 0, 0, 0, 32'h480, 32'h2001, 32'h10, 1, 32'h2010, 1, 0, 0};
    tbl[6] = '{1, 0, 0, 3'b011, 1, 1, 1, 32'h500, 0, 32'h8, 0, 32'h508, 0, 0, 1};
    tbl[7] = '{1, 1, 1, 3'b000, 0, 0, 0, 32'h600, 32'h3000, 32'h4, 1, 32'h3004, 1, 0, 0};
    tbl[8] = '{1, 0, 0, 3'b110, 0, 0, 0, 32'h700, 0, 32'h100, 0, 32'h800, 0, 0, 0};
    tbl[9] = '{1, 0, 0, 3'b000, 1, 0, 0, 32'h100, 0, 32'h2, 0, 32'h102, 0, 1, 0};
    for (int i = 0; i < 10; i++) begin
      drive(1, tbl[i].b, tbl[i].j, tbl[i].jr, tbl[i].f3, tbl[i].eq, tbl[i].lt, tbl[i].ltu,
            tbl[i].pc, tbl[i].rs1, tbl[i].imm);
      cycle();
      chk($sformatf("vec%0d_rv", i), redirect_vld, tbl[i].e_rv);
      chk($sformatf("vec%0d_pc", i), redirect_pc, tbl[i].e_rpc);
      chk($sformatf("vec%0d_lv", i), link_vld, tbl[i].e_lv);
      chk($sformatf("vec%0d_mis", i), misalign, tbl[i].e_mis);
      chk($sformatf("vec%0d_ill", i), illegal_br, tbl[i].e_ill);
      chk($sformatf("vec%0d_ld", i), link_data, tbl[i].pc + 32'd4);
      idle(3);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b, pc, rs1, imm;
      int t;
      a   = $urandom_range(0, 3) == 0 ? 32'h0 : $urandom;
      b   = $urandom_range(0, 2) == 0 ? a : $urandom;
      pc  = $urandom & 32'hFFFF_FFFC;
      rs1 = $urandom;
      imm = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      t   = $urandom_range(0, 7);
      drive($urandom_range(0, 3) != 0, t < 4 || t == 7, t == 4 || t == 7, t == 5,
            3'($urandom_range(0, 7)), a == b, $signed(a) < $signed(b), a < b, pc, rs1, imm);
      if (t == 6) ex_is_br = 0;
      cycle();
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
